capture_controller: RTL
=======================

# capture_controller

Acquisition sequencer for the 4-channel logic analyzer, directly upstream of the write organizer. It synchronizes the probe inputs and divides the system clock into sample ticks. It waits for a masked pattern or edge trigger, then issues one `write_address`/`data_source` pair per tick until the selected mode's buffer depth is filled. The memory banks' write enables are gated by `wr_valid`, and `write_address` parks out of range (16'hFFFF) whenever no capture is running.

## Interface
- `ADDR_W`, 16, width of `write_address`
- `BANK_DEPTH`, 8192, samples per 1-bit memory bank
- `DIV_W`, 16, width of the sample-rate divider
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `arm`  in  1  single-cycle pulse; starts an acquisition
- `abort`  in  1  single-cycle pulse; cancels any acquisition
- `mode`  in  2  0 = single, 1 = dual, 2 = multi channel, 3 = invalid; latched on accepted `arm`
- `div`  in  DIV_W  sample period minus one, in clocks; latched on accepted `arm`
- `trig_mask`  in  4  channels taking part in the trigger; latched on `arm`
- `trig_value`  in  4  required level per masked channel; latched on `arm`
- `trig_edge`  in  1  0 = level trigger, 1 = rising-edge-of-match trigger; latched on `arm`
- `probe_in`  in  4  asynchronous probe lines
- `data_source`  out  4  sample being written
- `write_address`  out  ADDR_W  sample index being written
- `wr_valid`  out  1  one-cycle write strobe
- `busy`  out  1  high in ARMED or CAPTURE
- `done`  out  1  high in DONE

## Operation
- Probe path: a 2-flop synchronizer on `probe_in`, giving `s_probe`.
- Capture depth from latched mode:
  - mode 0: 4×`BANK_DEPTH` (32768)
  - mode 1: 2×`BANK_DEPTH` (16384)
  - mode 2: `BANK_DEPTH` (8192)
  - mode 3: `arm` is ignored and the block stays in IDLE.
- Match definition: `match = ((s_probe ^ trig_value) & trig_mask) == 0`. With mask 0, `match` is always 1.
- States:
  - IDLE: on `arm` (mode ≠ 3), latch the configuration, clear the prescaler, set `prev_match` = 1, go to ARMED.
  - ARMED: on each sample tick, evaluate `match`, then set `prev_match` ← `match`. The trigger fires when `match` is true (level mode) or when `match && !prev_match` (edge mode). On trigger, the triggering sample is written at address 0 and the state goes to CAPTURE.
  - CAPTURE: on each tick, write the sample at `count`, then increment `count`. The write at depth−1 moves the state to DONE.
  - DONE: hold. `arm` restarts as from IDLE.
- `abort` moves any state to IDLE. It wins over a simultaneous `arm` and over a tick.
- `arm` is ignored in ARMED and CAPTURE.
- Edge mode with mask 0 never triggers; only `abort` exits.
- `count` is `ADDR_W` bits and never wraps. The maximum issued address is depth−1 (32767).

## Timing
- Reset values: `data_source` = 0, `write_address` = 16'hFFFF, `wr_valid` = 0, `busy` = 0, `done` = 0. State is IDLE, `count` = 0, prescaler = 0.
- Reset asserted mid-capture clears everything immediately; no further `wr_valid` is issued.
- Prescaler: a tick occurs when the prescaler equals `div`, after which it reloads to 0.
  - `div` = 0 gives a tick every clock.
  - `div` = N gives a tick every N+1 clocks.
  - The first tick after `arm` comes `div`+1 clocks later.
- Probe latency: a `probe_in` change is visible in `s_probe` after 2 clocks.
- Write latency: a tick in cycle t produces registered `wr_valid`, `write_address` and `data_source` in cycle t+1, with `data_source` = `s_probe` at t.
- `write_address` returns to 16'hFFFF in every cycle without `wr_valid`.
- `done` rises in the same cycle as the final `wr_valid`. `busy` falls in that cycle.
- Abort during CAPTURE: a tick coinciding with `abort` is not written.

## Structure
- Package `la_pkg`:
  - state enum (IDLE, ARMED, CAPTURE, DONE)
  - mode codes (MODE_SINGLE = 0, MODE_DUAL = 1, MODE_MULTI = 2)
  - `BANK_DEPTH`
  - `ADDR_PARK` = 16'hFFFF
  - function `depth_of(mode)`
- Sub-module `sample_tick_gen`: the `DIV_W` prescaler with `clear` and `div` inputs and a `tick` output.
- Everything else stays in `capture_controller`: FSM, synchronizer, trigger and address counter.

## Test plan
- Reset mid-capture: mode 2, `div` = 0, mask 0, level; assert `rst_n` low after 100 writes → all outputs at reset values; no `wr_valid` until the next `arm`.
- Full run, mode 2, `div` = 0, mask 0, level; `arm` → triggers on the first tick, exactly 8192 strobes at addresses 0..8191, `done` with the last strobe, `write_address` = 16'hFFFF afterwards.
- Prescaler, mode 0, `div` = 3 → 32768 strobes spaced 4 clocks apart; last address 32767; `busy` falls with the last strobe.
- Edge trigger: mask 4'b0001, value 4'b0001, `trig_edge` = 1, with `probe_in[0]` already high at `arm` → no trigger. Drop then raise it → the first write carries `data_source[0]` = 1 at address 0.
- Abort and invalid mode: `abort` at address 500 in mode 1 → IDLE within 1 clock, no further strobes. A following `arm` with mode 3 is ignored (`busy` stays 0).
- Simultaneous `arm` + `abort` in IDLE → stays IDLE. `arm` in DONE → a new capture restarts at address 0.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture path.
package la_pkg;

  localparam int          ADDR_W     = 16;
  localparam int          BANK_DEPTH = 8192;
  localparam int          DIV_W      = 16;
  localparam logic [15:0] ADDR_PARK  = 16'hFFFF;

  localparam logic [1:0] MODE_SINGLE  = 2'd0;
  localparam logic [1:0] MODE_DUAL    = 2'd1;
  localparam logic [1:0] MODE_MULTI   = 2'd2;
  localparam logic [1:0] MODE_INVALID = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Samples per acquisition; fewer channels per sample means more banks per channel.
  function automatic int depth_of(input logic [1:0] mode, input int bank_depth);
    case (mode)
      MODE_SINGLE: depth_of = 32'sd4 * bank_depth;
      MODE_DUAL:   depth_of = 32'sd2 * bank_depth;
      MODE_MULTI:  depth_of = bank_depth;
      default:     depth_of = 32'sd0;
    endcase
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate prescaler: one tick every div+1 clocks, restartable with clear.
module sample_tick_gen
  import la_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  assign tick = (r_cnt == div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {DIV_W{1'b0}};
    end else if (clear) begin
      r_cnt <= {DIV_W{1'b0}};
    end else if (tick) begin
      r_cnt <= {DIV_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + DIV_W'(1'b1);
    end
  end

endmodule

// File: rtl/capture_controller.sv
// Acquisition sequencer: synchronizes probes, waits for a trigger, then
// emits one write address/sample pair per sample tick until the buffer is full.
module capture_controller #(
  parameter int ADDR_W     = 16,
  parameter int BANK_DEPTH = 8192,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [3:0]        trig_mask,
  input  logic [3:0]        trig_value,
  input  logic              trig_edge,
  input  logic [3:0]        probe_in,
  output logic [3:0]        data_source,
  output logic [ADDR_W-1:0] write_address,
  output logic              wr_valid,
  output logic              busy,
  output logic              done
);
  import la_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_sync1;
  logic [3:0]        r_s_probe;
  logic [DIV_W-1:0]  r_div;
  logic [3:0]        r_mask;
  logic [3:0]        r_value;
  logic              r_edge;
  logic              r_prev_match;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_last;
  logic [3:0]        r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_valid;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_match;
  logic              w_trig;
  logic              w_accept;
  logic              w_write;
  logic [ADDR_W-1:0] w_addr;

  sample_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_accept),
    .div   (r_div),
    .tick  (w_tick)
  );

  assign w_match  = (((r_s_probe ^ r_value) & r_mask) == 4'd0);
  assign w_trig   = r_edge ? (w_match && !r_prev_match) : w_match;
  assign w_accept = arm && !abort && (mode != MODE_INVALID) &&
                    ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            w_state_nxt = ARMED;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ARMED: begin
          if (w_tick && w_trig) begin
            w_state_nxt = CAPTURE;
          end else begin
            w_state_nxt = ARMED;
          end
        end
        CAPTURE: begin
          if (w_tick && (r_count == r_last)) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = CAPTURE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // A tick that coincides with abort is dropped.
  always_comb begin
    w_write = 1'b0;
    w_addr  = {ADDR_W{1'b0}};
    case (r_state)
      ARMED: begin
        if (w_tick && w_trig && !abort) begin
          w_write = 1'b1;
          w_addr  = {ADDR_W{1'b0}};
        end else begin
          w_write = 1'b0;
          w_addr  = {ADDR_W{1'b0}};
        end
      end
      CAPTURE: begin
        if (w_tick && !abort) begin
          w_write = 1'b1;
          w_addr  = r_count;
        end else begin
          w_write = 1'b0;
          w_addr  = {ADDR_W{1'b0}};
        end
      end
      default: begin
        w_write = 1'b0;
        w_addr  = {ADDR_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1      <= 4'd0;
      r_s_probe    <= 4'd0;
      r_div        <= {DIV_W{1'b0}};
      r_mask       <= 4'd0;
      r_value      <= 4'd0;
      r_edge       <= 1'b0;
      r_prev_match <= 1'b1;
      r_count      <= {ADDR_W{1'b0}};
      r_last       <= {ADDR_W{1'b0}};
      r_data       <= 4'd0;
      r_addr       <= ADDR_W'(ADDR_PARK);
      r_wr_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_sync1   <= probe_in;
      r_s_probe <= r_sync1;

      if (w_accept) begin
        r_div        <= div;
        r_mask       <= trig_mask;
        r_value      <= trig_value;
        r_edge       <= trig_edge;
        r_prev_match <= 1'b1;
        r_count      <= {ADDR_W{1'b0}};
        r_last       <= ADDR_W'(depth_of(mode, BANK_DEPTH) - 32'sd1);
      end else if ((r_state == ARMED) && w_tick && !abort) begin
        r_prev_match <= w_match;
        if (w_trig) begin
          r_count <= ADDR_W'(1'b1);
        end else begin
          r_count <= r_count;
        end
      end else if ((r_state == CAPTURE) && w_tick && !abort) begin
        r_count <= r_count + ADDR_W'(1'b1);
      end else begin
        r_count <= r_count;
      end

      r_wr_valid <= w_write;
      r_addr     <= w_write ? w_addr : ADDR_W'(ADDR_PARK);
      r_data     <= w_write ? r_s_probe : 4'd0;
      r_busy     <= (w_state_nxt == ARMED) || (w_state_nxt == CAPTURE);
      r_done     <= (w_state_nxt == DONE);
    end
  end

  assign data_source   = r_data;
  assign write_address = r_addr;
  assign wr_valid      = r_wr_valid;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
